// File: rtl/arcsine_search_pkg.sv
// Shared definitions for the arcsine phase search and the quarter-wave ROM.
// Holds the 64-entry quarter-sine table, datapath widths and FSM state encoding.
package arcsine_search_pkg;

   localparam int unsigned TABLE_DEPTH = 64;
   localparam int unsigned IDX_W       = 6;
   localparam int unsigned MAG_W       = 7;
   localparam int unsigned SAMPLE_W    = 8;
   localparam int unsigned PHASE_W     = 8;
   localparam int unsigned K_W         = 3;

   // First quarter of a sine period, amplitude 127, sampled at 64 points
   localparam logic [MAG_W-1:0] QW_TABLE [TABLE_DEPTH] = '{
      7'd1,   7'd4,   7'd7,   7'd10,  7'd13,  7'd16,  7'd19,  7'd23,
      7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
      7'd49,  7'd52,  7'd55,  7'd58,  7'd61,  7'd63,  7'd66,  7'd69,
      7'd71,  7'd74,  7'd77,  7'd79,  7'd81,  7'd84,  7'd86,  7'd88,
      7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Magnitude of a signed sample; -128 saturates to 127
   function automatic logic [MAG_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-1:0] neg;
      neg = ~s + SAMPLE_W'(1);
      if (s == 8'h80)
         return MAG_W'(127);
      else if (s[SAMPLE_W-1])
         return neg[MAG_W-1:0];
      else
         return s[MAG_W-1:0];
   endfunction

   // Falling quarter mirrors the index within the quarter
   function automatic logic [PHASE_W-1:0] make_phase(input logic sign,
                                                     input logic slope_neg,
                                                     input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] q;
      q = slope_neg ? (IDX_W'(TABLE_DEPTH - 1) - idx) : idx;
      return {sign, slope_neg, q};
   endfunction

endpackage

// File: rtl/arcsine_search_quarter_sine_rom.sv
// Combinational quarter-wave sine lookup, shared with the forward sine generator.
module quarter_sine_rom
   import arcsine_search_pkg::*;
(
   input  logic [IDX_W-1:0] addr,
   output logic [MAG_W-1:0] value_c
);

   assign value_c = QW_TABLE[addr];

endmodule

// File: rtl/arcsine_search.sv
// Recovers sine phase from an amplitude by binary search over the quarter-wave table.
// Optional ARCSINE_EXACT_FLAG_EN adds a flag for an exact table hit.
module arcsine_search
   import arcsine_search_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                slope_neg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PHASE_W-1:0]  phase,
   output logic                exact
);

   state_e             state;
   logic [IDX_W-1:0]   idx;
   logic [K_W-1:0]     k;
   logic [MAG_W-1:0]   mag;
   logic               sign_q;
   logic               slope_q;

   logic [IDX_W-1:0]   trial_c;
   logic [IDX_W-1:0]   rom_addr_c;
   logic [IDX_W-1:0]   step_idx_c;
   logic [MAG_W-1:0]   rom_trial_c;

   // idx only carries bits above k, so OR-ing in 2^k equals idx + 2^k
   assign trial_c    = idx | (IDX_W'(1) << k);
   assign rom_addr_c = trial_c - IDX_W'(1);
   assign step_idx_c = (rom_trial_c < mag) ? trial_c : idx;

   quarter_sine_rom u_rom_trial (
      .addr    (rom_addr_c),
      .value_c (rom_trial_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         phase     <= '0;
         idx       <= '0;
         k         <= K_W'(5);
         mag       <= '0;
         sign_q    <= 1'b0;
         slope_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  mag      <= abs_sat(sample);
                  sign_q   <= sample[SAMPLE_W-1];
                  slope_q  <= slope_neg;
                  idx      <= '0;
                  k        <= K_W'(5);
                  in_ready <= 1'b0;
                  state    <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               idx <= step_idx_c;
               if (k == '0) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  phase     <= make_phase(sign_q, slope_q, step_idx_c);
               end else begin
                  k <= k - K_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef ARCSINE_EXACT_FLAG_EN
   logic [MAG_W-1:0] rom_final_c;
   logic             exact_q;

   // Second lookup checks the final index in the same cycle the phase is latched
   quarter_sine_rom u_rom_final (
      .addr    (step_idx_c),
      .value_c (rom_final_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         exact_q <= 1'b0;
      else if (state == ST_SEARCH && k == '0)
         exact_q <= (rom_final_c == mag);
   end

   assign exact = exact_q;
`else
   assign exact = 1'b0;
`endif

endmodule

// File: tb/tb_arcsine_search.sv
// Self-checking bench for arcsine_search: vector table, corner sequences, exhaustive sweep.
module tb_arcsine_search;

`ifdef ARCSINE_EXACT_FLAG_EN
   localparam bit EXACT_EN = 1'b1;
`else
   localparam bit EXACT_EN = 1'b0;
`endif

   localparam int REF_ROM [64] = '{
      1, 4, 7, 10, 13, 16, 19, 23, 26, 29, 32, 35, 38, 41, 44, 47,
      49, 52, 55, 58, 61, 63, 66, 69, 71, 74, 77, 79, 81, 84, 86, 88,
      91, 93, 95, 97, 99, 101, 103, 105, 106, 108, 110, 111, 113, 114, 115, 117,
      118, 119, 120, 121, 122, 123, 124, 124, 125, 125, 126, 126, 127, 127, 127, 127
   };

   typedef struct {
      logic [7:0] phase;
      logic       exact;
   } exp_t;

   typedef struct {
      logic [7:0] s;
      logic       sl;
      logic [7:0] ph;
      logic       ex;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sample;
   logic       slope_neg;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] phase;
   logic       exact;

   exp_t sb[$];
   vec_t vecs[9];
   int   n_checks = 0;
   int   n_pass   = 0;

   arcsine_search dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sample    (sample),
      .slope_neg (slope_neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .phase     (phase),
      .exact     (exact)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [7:0] s, input logic sl);
      exp_t e;
      int   m;
      int   idx;
      int   q;
      m = (s == 8'h80) ? 127 : (s[7] ? (256 - int'(s)) : int'(s));
      idx = 0;
      for (int i = 0; i < 64; i++)
         if (REF_ROM[i] < m) idx++;
      q = sl ? (63 - idx) : idx;
      e.phase = {s[7], sl, 6'(q)};
      e.exact = EXACT_EN && (REF_ROM[idx] == m);
      return e;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
   endtask

   // One transaction: accept, scramble inputs during search, pop and compare result
   task automatic run_one(input logic [7:0] s, input logic sl, input exp_t e,
                          input string tag);
      int   lat;
      exp_t got;
      @(negedge clk);
      wait_ready();
      in_valid  = 1'b1;
      sample    = s;
      slope_neg = sl;
      sb.push_back(e);
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
         in_valid  = 1'($urandom);
         sample    = 8'($urandom);
         slope_neg = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, lat, 6);
      if (sb.size() == 0) begin
         check({tag, " scoreboard"}, 0, 1);
      end else begin
         got = sb.pop_front();
         check({tag, " phase"}, phase, got.phase);
         check({tag, " exact"}, exact, got.exact);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      exp_t e;
      exp_t held;
      int   w;

      vecs[0] = '{8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'h7F, 1'b0, 8'h3C, 1'b1};
      vecs[2] = '{8'h81, 1'b1, 8'hC3, 1'b1};
      vecs[3] = '{8'h31, 1'b0, 8'h10, 1'b1};
      vecs[4] = '{8'h40, 1'b0, 8'h16, 1'b0};
      vecs[5] = '{8'h80, 1'b0, 8'hBC, 1'b1};
      vecs[6] = '{8'h01, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'h01, 1'b1, 8'h7F, 1'b1};
      vecs[8] = '{8'hFF, 1'b0, 8'h80, 1'b1};

      rst = 1'b1; in_valid = 1'b0; sample = '0; slope_neg = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset phase", phase, 0);
      check("reset exact", exact, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         e.phase = vecs[i].ph;
         e.exact = vecs[i].ex & EXACT_EN;
         run_one(vecs[i].s, vecs[i].sl, e, $sformatf("vec%0d", i));
      end

      // Backpressure: result held while out_ready low, in_valid ignored
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1; sample = 8'd49; slope_neg = 1'b0;
      e.phase = 8'h10; e.exact = EXACT_EN;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("bp out_valid", out_valid, 1);
      held = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         sample   = 8'($urandom);
         @(negedge clk);
         check($sformatf("bp%0d out_valid", c), out_valid, 1);
         check($sformatf("bp%0d in_ready", c), in_ready, 0);
         check($sformatf("bp%0d phase", c), phase, held.phase);
         check($sformatf("bp%0d exact", c), exact, held.exact);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp release out_valid", out_valid, 0);
      check("bp release in_ready", in_ready, 1);

      // Reset mid-search discards the transaction
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1; sample = 8'd127; slope_neg = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst in_ready", in_ready, 1);
      check("midrst phase", phase, 0);
      check("midrst exact", exact, 0);
      @(negedge clk);
      rst = 1'b0;
      e.phase = 8'h3C; e.exact = EXACT_EN;
      run_one(8'd127, 1'b0, e, "post_rst");

      for (int s = 0; s < 256; s++) begin
         for (int sl = 0; sl < 2; sl++) begin
            e = model(8'(s), 1'(sl));
            run_one(8'(s), 1'(sl), e, $sformatf("exh s=%0d sl=%0d", s, sl));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arcsine_search.md
ARCSINE_SEARCH -- requirements
Module: arcsine_search

Interface
REQ-001 SHALL have no parameters; table size fixed at 64 entries, 8-bit phase.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  sample offered.
REQ-005 in_ready  output  1  block can accept sample.
REQ-006 sample  input  8  signed two's-complement amplitude.
REQ-007 slope_neg  input  1  0 = rising quarter (phase[6]=0), 1 = falling quarter (phase[6]=1).
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 phase  output  8  recovered phase, 256 steps per period.
REQ-011 exact  output  1  table entry at result index equals magnitude.

Function
REQ-012 SHALL invert the 64-entry quarter-wave table: rom[0..63] = 1,4,7,10,13,16,19,23,26,29,32,35,38,41,44,47,49,52,55,58,61,63,66,69,71,74,77,79,81,84,86,88,91,93,95,97,99,101,103,105,106,108,110,111,113,114,115,117,118,119,120,121,122,123,124,124,125,125,126,126,127,127,127,127.
REQ-013 SHALL capture on in_valid&in_ready: m = |sample| (7 bits), -128 saturating to 127; sign = sample[7]; slope_neg.
REQ-014 States IDLE, SEARCH, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE->SEARCH on acceptance edge; idx cleared to 0, bit counter k=5.
REQ-016 SEARCH, one step per cycle: trial = idx + 2^k; if rom[trial-1] < m then idx = trial; k decrements; after k=0 step -> DONE.
REQ-017 Result idx SHALL equal count of entries < m (smallest i with rom[i] >= m); range 0..60.
REQ-018 Latency: out_valid high 6 cycles after the acceptance edge (6 SEARCH cycles).
REQ-019 phase = {sign, slope_neg, slope_neg ? 63-idx : idx}, registered, stable while out_valid.
REQ-020 DONE held with phase/exact stable until out_ready=1; DONE&out_ready -> IDLE; no acceptance in the same cycle (throughput one per 8 cycles minimum).
REQ-021 in_valid outside IDLE ignored; sample/slope_neg changes during SEARCH do not affect the result.
REQ-022 out_ready outside DONE ignored.

Reset
REQ-023 rst asserted SHALL immediately force IDLE, in_ready=1, out_valid=0, phase=0, exact=0, idx=0, k=5, regardless of state; in-flight search discarded.

Configuration
REQ-024 Macro ARCSINE_EXACT_FLAG_EN: defined -> exact = (rom[idx] == m) registered with phase; undefined -> exact tied 0, no comparator/register; phase behaviour identical either way.

Structure
REQ-025 Shared package holds the 64-entry quarter-wave table constant, table depth (64), index width (6), phase width (8), and state encoding.
REQ-026 Sub-module quarter_sine_rom: combinational 6-bit address -> 7-bit value from the package table, reusable by the forward sine generator.

Verification
REQ-027 sample=0, slope_neg=0 -> phase=0x00, exact=0, out_valid 6 cycles after acceptance.
REQ-028 sample=127, slope_neg=0 -> phase=0x3C, exact=1; sample=-127, slope_neg=1 -> phase=0xC3, exact=1.
REQ-029 sample=49, slope_neg=0 -> phase=0x10, exact=1; sample=64, slope_neg=0 -> phase=0x16, exact=0; sample=-128, slope_neg=0 -> phase=0xBC, exact=1.
REQ-030 Backpressure: out_ready low 5 cycles in DONE -> phase/exact/out_valid stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-031 rst pulsed during 3rd SEARCH cycle -> out_valid=0, in_ready=1, phase=0 immediately; next sample=127 yields 0x3C normally.
REQ-032 Exhaustive: all 256 samples x both slopes vs reference model of REQ-017/019; with ARCSINE_EXACT_FLAG_EN undefined, exact always 0.
